i2s_pcm_tx: RTL and testbench

- Serial audio stage directly downstream of the SID API; it consumes the SID stereo output word (audio_o) and drives it to the SGTL5000 in I2S PCM Format A (DSP mode).
- The codec is bus master: it supplies SCLK and a one-SCLK-wide LRCLK frame-sync pulse. This block oversamples both in the 24 MHz clk domain.
- Optionally deserializes codec ADC data (pad_dout) back into audio_i.

---
 rtl/i2s_pcm_tx.sv | 139 +++++++++++++
 tb/tb_i2s_pcm_tx.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/i2s_pcm_tx.sv
// rtl/i2s_pcm_tx.sv - I2S DSP-mode A PCM transmitter slaved to codec SCLK/LRCLK
// Optional ADC deserializer onto audio_i is built when I2S_RX_EN is defined.
module i2s_pcm_tx #(
  parameter int BITS = 48
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pad_sclk,
  input  logic            pad_lrclk,
  output logic            pad_din,
  input  logic            pad_dout,
  input  logic [BITS-1:0] audio_o,
  output logic            sample_req,
  output logic [BITS-1:0] audio_i,
  output logic            audio_i_valid,
  output logic            frame_err
);

  localparam int            CW       = $clog2(BITS + 1);
  localparam logic [CW-1:0] CNT_IDLE = CW'(BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(BITS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BITS-1:0] tx_q, tx_d;
  logic            din_d, req_d, err_d;

  logic sclk_s1, sclk_s2, sclk_s3;
  logic lrclk_s1, lrclk_s2;
  logic sclk_rise, sclk_fall, frame_start, bit_rise;

  // lrclk shares the sclk stage depth so it is coherent with the detected edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s1  <= 1'b0;
      sclk_s2  <= 1'b0;
      sclk_s3  <= 1'b0;
      lrclk_s1 <= 1'b0;
      lrclk_s2 <= 1'b0;
    end else begin
      sclk_s1  <= pad_sclk;
      sclk_s2  <= sclk_s1;
      sclk_s3  <= sclk_s2;
      lrclk_s1 <= pad_lrclk;
      lrclk_s2 <= lrclk_s1;
    end
  end

  assign sclk_rise   = sclk_s2 & ~sclk_s3;
  assign sclk_fall   = ~sclk_s2 & sclk_s3;
  assign frame_start = sclk_rise & lrclk_s2;
  assign bit_rise    = sclk_rise & ~lrclk_s2 & (state_q == SHIFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= CNT_IDLE;
      tx_q       <= '0;
      pad_din    <= 1'b0;
      sample_req <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_q       <= tx_d;
      pad_din    <= din_d;
      sample_req <= req_d;
      frame_err  <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    din_d   = pad_din;
    req_d   = 1'b0;
    err_d   = 1'b0;
    if (frame_start) begin
      // A restart while bits are already counted discards the partial frame
      tx_d    = audio_o;
      req_d   = 1'b1;
      cnt_d   = '0;
      state_d = SHIFT;
      err_d   = (state_q == SHIFT) && (cnt_q != '0);
    end else if (bit_rise) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) begin
        state_d = IDLE;
      end
    end else if (sclk_fall) begin
      if (state_q == SHIFT) begin
        din_d = tx_q[BITS-1];
        tx_d  = {tx_q[BITS-2:0], 1'b0};
      end else begin
        din_d = 1'b0;
      end
    end
  end

`ifdef I2S_RX_EN
  logic            dout_s1, dout_s2;
  logic [BITS-1:0] rx_q;
  logic            rx_last;

  assign rx_last = bit_rise && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_s1       <= 1'b0;
      dout_s2       <= 1'b0;
      rx_q          <= '0;
      audio_i       <= '0;
      audio_i_valid <= 1'b0;
    end else begin
      dout_s1       <= pad_dout;
      dout_s2       <= dout_s1;
      audio_i_valid <= rx_last;
      if (bit_rise) begin
        rx_q <= {rx_q[BITS-2:0], dout_s2};
      end
      if (rx_last) begin
        audio_i <= {rx_q[BITS-2:0], dout_s2};
      end
    end
  end
`else
  logic unused_dout;
  assign unused_dout   = pad_dout;
  assign audio_i       = '0;
  assign audio_i_valid = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_pcm_tx.sv
// tb/tb_i2s_pcm_tx.sv - directed and randomized frame checks for i2s_pcm_tx
`timescale 1ns/1ps
module tb_i2s_pcm_tx;
  localparam int BITS      = 48;
  localparam int SCLK_HALF = 163;
`ifdef I2S_RX_EN
  localparam int RX_ON = 1;
`else
  localparam int RX_ON = 0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            pad_sclk = 1'b0;
  logic            pad_lrclk = 1'b0;
  logic            pad_dout = 1'b0;
  logic            pad_din;
  logic [BITS-1:0] audio_o = '0;
  logic            sample_req;
  logic [BITS-1:0] audio_i;
  logic            audio_i_valid;
  logic            frame_err;

  int checks = 0;
  int failures = 0;
  int req_cnt = 0;
  int err_cnt = 0;
  int valid_cnt = 0;

  always #20.833 clk = ~clk;

  i2s_pcm_tx #(.BITS(BITS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pad_sclk     (pad_sclk),
    .pad_lrclk    (pad_lrclk),
    .pad_din      (pad_din),
    .pad_dout     (pad_dout),
    .audio_o      (audio_o),
    .sample_req   (sample_req),
    .audio_i      (audio_i),
    .audio_i_valid(audio_i_valid),
    .frame_err    (frame_err)
  );

  always @(negedge clk) begin
    if (sample_req) req_cnt++;
    if (frame_err) err_cnt++;
    if (audio_i_valid) valid_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BITS-1:0] rand48();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[BITS-1:0];
  endfunction

  // One codec SCLK period: codec updates lrclk/dout on the fall, samples din at the rise
  task automatic sclk_cycle(input logic lr, input logic d, output logic din);
    pad_sclk  = 1'b0;
    pad_lrclk = lr;
    pad_dout  = d;
    #(SCLK_HALF);
    din = pad_din;
    pad_sclk = 1'b1;
    #(SCLK_HALF);
  endtask

  // Frame start then n_bits data periods; got holds what the codec sampled on rises 1..BITS
  task automatic run_frame(input logic [BITS-1:0] rx_word, input int n_bits,
                           input logic swap, input logic [BITS-1:0] swap_word,
                           output logic [BITS-1:0] got, output int tail_ones);
    logic b;
    int   r0;
    logic seen;
    got = '0;
    tail_ones = 0;
    r0 = req_cnt;
    sclk_cycle(1'b1, 1'b0, b);
    if (swap) begin
      seen = 1'b0;
      for (int i = 0; i < 16 && !seen; i++) begin
        @(negedge clk);
        if (req_cnt != r0) seen = 1'b1;
      end
      chk("swap_req_seen", 64'(seen), 64'd1);
      @(negedge clk);
      audio_o = swap_word;
    end
    for (int k = 1; k <= n_bits; k++) begin
      sclk_cycle(1'b0, (k <= BITS) ? rx_word[BITS-k] : 1'b0, b);
      if (k <= BITS) got[BITS-k] = b;
      else if (b) tail_ones++;
    end
    #(400);
  endtask

  task automatic full_frame(input string tag, input logic [BITS-1:0] tx, input logic [BITS-1:0] rx,
                            input int n_bits, input logic swap, input logic [BITS-1:0] swap_word);
    logic [BITS-1:0] got;
    int tail, r0, e0, v0;
    r0 = req_cnt; e0 = err_cnt; v0 = valid_cnt;
    audio_o = tx;
    run_frame(rx, n_bits, swap, swap_word, got, tail);
    chk({tag, "_data"}, 64'(got), 64'(tx));
    chk({tag, "_tail"}, 64'(tail), 64'd0);
    chk({tag, "_req"}, 64'(req_cnt - r0), 64'd1);
    chk({tag, "_err"}, 64'(err_cnt - e0), 64'd0);
    chk({tag, "_valid"}, 64'(valid_cnt - v0), 64'(RX_ON));
    chk({tag, "_audio_i"}, 64'(audio_i), (RX_ON != 0) ? 64'(rx) : 64'd0);
  endtask

  initial begin
    logic            b;
    logic [BITS-1:0] got, w1, w2, rx;
    int              tail, r0, e0, v0;

    // Reset held while SCLK runs with LRCLK idle
    audio_o = 48'hA5A5A5_3C3C3C;
    for (int i = 0; i < 6; i++) begin
      sclk_cycle(1'b0, 1'b0, b);
      chk("rst_din", 64'(b), 64'd0);
    end
    chk("rst_req", 64'(req_cnt), 64'd0);
    chk("rst_audio_i", 64'(audio_i), 64'd0);
    chk("rst_valid", 64'(valid_cnt), 64'd0);
    chk("rst_err", 64'(err_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sclk_cycle(1'b0, 1'b0, b);
      chk("idle_din", 64'(b), 64'd0);
    end
    chk("idle_req", 64'(req_cnt), 64'd0);

    // Known pattern, audio_o swapped right after the latch
    full_frame("fA", 48'hA5A5A5_3C3C3C, 48'h123456_FEDCBA, 64, 1'b1, 48'h000001_800000);
    full_frame("fB", 48'h000001_800000, rand48(), 64, 1'b0, '0);

    // Short frame of 20 bits, then a restart carrying the current audio_o
    r0 = req_cnt; e0 = err_cnt; v0 = valid_cnt;
    w1 = rand48();
    w2 = rand48();
    rx = rand48();
    audio_o = w1;
    run_frame(rand48(), 20, 1'b0, '0, got, tail);
    chk("short_valid_none", 64'(valid_cnt - v0), 64'd0);
    chk("short_err_none_yet", 64'(err_cnt - e0), 64'd0);
    audio_o = w2;
    run_frame(rx, 60, 1'b0, '0, got, tail);
    chk("short_err", 64'(err_cnt - e0), 64'd1);
    chk("short_req", 64'(req_cnt - r0), 64'd2);
    chk("restart_data", 64'(got), 64'(w2));
    chk("restart_tail", 64'(tail), 64'd0);
    chk("restart_valid", 64'(valid_cnt - v0), 64'(RX_ON));
    chk("restart_audio_i", 64'(audio_i), (RX_ON != 0) ? 64'(rx) : 64'd0);

    // LRCLK high for two SCLKs: second start sees counter 0, so no error
    e0 = err_cnt;
    w1 = rand48();
    audio_o = w1;
    sclk_cycle(1'b1, 1'b0, b);
    run_frame(rand48(), 52, 1'b0, '0, got, tail);
    chk("lr2_err", 64'(err_cnt - e0), 64'd0);
    chk("lr2_data", 64'(got), 64'(w1));

    for (int n = 0; n < 4; n++) begin
      full_frame("rnd", rand48(), rand48(), BITS + $urandom_range(2, 16), 1'b0, '0);
    end

    // Reset asserted at bit 10 of an all-ones frame
    audio_o = '1;
    run_frame(rand48(), 10, 1'b0, '0, got, tail);
    chk("mid_din_before", 64'(pad_din), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_din_async", 64'(pad_din), 64'd0);
    chk("mid_audio_i", 64'(audio_i), 64'd0);
    #(200);
    @(negedge clk);
    rst_n = 1'b1;
    r0 = req_cnt;
    for (int i = 0; i < 6; i++) begin
      sclk_cycle(1'b0, 1'b0, b);
      chk("post_rst_din", 64'(b), 64'd0);
    end
    chk("post_rst_req", 64'(req_cnt - r0), 64'd0);
    full_frame("post_rst", rand48(), rand48(), 56, 1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
